// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: TMDS receive channel. Bit-slip word alignment
// on control tokens, then 10b -> 8b / control / DE decode.
module tmds_channel_decoder #(
  parameter int LOCK_TOKENS   = 64,
  parameter int SEARCH_WINDOW = 4096,
  parameter int SLIP_WAIT     = 16
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic [9:0] raw_din,
  output logic       bitslip,
  output logic       aligned,
  output logic       lock_lost,
  output logic [7:0] data_out,
  output logic       de,
  output logic       c0,
  output logic       c1
);

  localparam int WW =
    (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
  localparam int RW = $clog2(LOCK_TOKENS + 1);
  localparam int CW =
    (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH,
    SLIP,
    WAIT,
    LOCKED
  } state_t;

  typedef struct packed {
    logic [9:0] word;
    logic       tok;
    logic [1:0] cc;
  } s1_t;

  logic [1:0]    rst_sync;
  logic          rst_n;
  s1_t           s1;
  s1_t           s1_d;
  state_t        state;
  state_t        state_d;
  logic [WW-1:0] win_cnt;
  logic [WW-1:0] win_d;
  logic [RW-1:0] tok_run;
  logic [RW-1:0] run_d;
  logic [RW-1:0] run_inc;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_d;
  logic          lost_d;
  logic          lock_hit;
  logic          win_end;
  logic [7:0]    d;
  logic [7:0]    dec;

  // Async assert, pclk-synchronous release of the internal reset
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // Classify the incoming word as token or data
  always_comb begin
    s1_d.word = raw_din;
    s1_d.tok  = 1'b1;
    s1_d.cc   = 2'b00;
    unique case (1'b1)
      (raw_din == TOK00): s1_d.cc = 2'b00;
      (raw_din == TOK01): s1_d.cc = 2'b01;
      (raw_din == TOK10): s1_d.cc = 2'b10;
      (raw_din == TOK11): s1_d.cc = 2'b11;
      default:            s1_d.tok = 1'b0;
    endcase
  end

  // Stage 1: word plus token flags
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) s1 <= '0;
    else        s1 <= s1_d;
  end

  // Alignment state and counters
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      win_cnt   <= '0;
      tok_run   <= '0;
      wait_cnt  <= '0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_d;
      win_cnt   <= win_d;
      tok_run   <= run_d;
      wait_cnt  <= wait_d;
      lock_lost <= lost_d;
    end
  end

  assign run_inc = (tok_run >= RW'(LOCK_TOKENS)) ?
                   tok_run : tok_run + RW'(1);
  assign lock_hit = s1.tok &&
                    (run_inc >= RW'(LOCK_TOKENS));
  assign win_end = (win_cnt == WW'(SEARCH_WINDOW - 1));

  // Next-state logic; lock beats window expiry
  always_comb begin
    state_d = state;
    win_d   = win_cnt;
    run_d   = tok_run;
    wait_d  = wait_cnt;
    lost_d  = 1'b0;
    unique case (state)
      SEARCH: begin
        win_d = win_cnt + WW'(1);
        run_d = s1.tok ? run_inc : '0;
        if (lock_hit) begin
          state_d = LOCKED;
          win_d   = '0;
          run_d   = '0;
        end else if (win_end) begin
          state_d = SLIP;
          win_d   = '0;
          run_d   = '0;
        end
      end
      SLIP: begin
        state_d = WAIT;
        wait_d  = '0;
      end
      WAIT: begin
        wait_d = wait_cnt + CW'(1);
        if (wait_cnt == CW'(SLIP_WAIT - 1)) begin
          state_d = SEARCH;
          win_d   = '0;
          run_d   = '0;
        end
      end
      LOCKED: begin
        win_d = s1.tok ? '0 : win_cnt + WW'(1);
        if (!s1.tok && win_end) begin
          state_d = SEARCH;
          win_d   = '0;
          run_d   = '0;
          lost_d  = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  assign aligned = (state == LOCKED);
  assign bitslip = (state == SLIP);

  // Undo the TMDS transition-minimising XOR/XNOR chain
  always_comb begin
    d = s1.word[9] ? ~s1.word[7:0] : s1.word[7:0];
    dec = '0;
    dec[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = s1.word[8] ? (d[i] ^ d[i-1]) :
                            ~(d[i] ^ d[i-1]);
    end
  end

  // Stage 2: gated decoded outputs
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      de       <= 1'b0;
      c0       <= 1'b0;
      c1       <= 1'b0;
    end else if (!aligned) begin
      data_out <= '0;
      de       <= 1'b0;
      c0       <= 1'b0;
      c1       <= 1'b0;
    end else if (s1.tok) begin
      data_out <= '0;
      de       <= 1'b0;
      c0       <= s1.cc[0];
      c1       <= s1.cc[1];
    end else begin
      data_out <= dec;
      de       <= 1'b1;
      c0       <= 1'b0;
      c1       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: randomized self-checking bench with a
// bit-slipping deserializer model and a DVI encoder reference.
module tb_tmds_channel_decoder;

  localparam int LT  = 64;
  localparam int SW  = 256;
  localparam int SWT = 16;

  localparam logic [9:0] T00  = 10'b1101010100;
  localparam logic [9:0] T01  = 10'b0010101011;
  localparam logic [9:0] T10  = 10'b0101010100;
  localparam logic [9:0] T11  = 10'b1010101011;
  localparam logic [9:0] IDLE = 10'h0FF;

  logic       pclk = 1'b0;
  logic       reset_n = 1'b1;
  logic [9:0] raw_din = '0;
  logic       bitslip;
  logic       aligned;
  logic       lock_lost;
  logic [7:0] data_out;
  logic       de;
  logic       c0;
  logic       c1;

  int checks = 0;
  int errors = 0;
  int slip_total = 0;
  int slip_base = 0;
  int off0 = 0;
  int disp = 0;

  tmds_channel_decoder #(
    .LOCK_TOKENS  (LT),
    .SEARCH_WINDOW(SW),
    .SLIP_WAIT    (SWT)
  ) dut (
    .pclk     (pclk),
    .reset_n  (reset_n),
    .raw_din  (raw_din),
    .bitslip  (bitslip),
    .aligned  (aligned),
    .lock_lost(lock_lost),
    .data_out (data_out),
    .de       (de),
    .c0       (c0),
    .c1       (c1)
  );

  always #5 pclk = ~pclk;

  // Deserializer model: each sampled pulse moves the boundary one bit
  always @(posedge pclk) begin
    if (bitslip === 1'b1) slip_total++;
  end

  function automatic int cur_off();
    return (off0 + slip_total - slip_base) % 10;
  endfunction

  function automatic logic [9:0] rot(input logic [9:0] w,
                                     input int k);
    logic [9:0] r;
    for (int j = 0; j < 10; j++) r[j] = w[(j + k) % 10];
    return r;
  endfunction

  function automatic bit is_tok(input logic [9:0] w);
    return (w == T00) || (w == T01) ||
           (w == T10) || (w == T11);
  endfunction

  function automatic logic [7:0] spec_dec(input logic [9:0] w);
    logic [7:0] dd;
    logic [7:0] r;
    dd = w[9] ? ~w[7:0] : w[7:0];
    r[0] = dd[0];
    for (int i = 1; i < 8; i++)
      r[i] = w[8] ? (dd[i] ^ dd[i-1]) : ~(dd[i] ^ dd[i-1]);
    return r;
  endfunction

  // Standard DVI 8b/10b TMDS encoder with running disparity
  task automatic enc(input logic [7:0] dd, output logic [9:0] q);
    logic [8:0] qm;
    int n1;
    int n1q;
    int n0q;
    n1 = $countones(dd);
    qm[0] = dd[0];
    if (n1 > 4 || (n1 == 4 && dd[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ dd[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ dd[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (disp == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      if (qm[8]) disp += n1q - n0q;
      else       disp += n0q - n1q;
    end else if ((disp > 0 && n1q > n0q) ||
                 (disp < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      disp += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      disp += -2 * int'(!qm[8]) + n1q - n0q;
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive(input logic [9:0] w);
    raw_din = rot(w, cur_off());
  endtask

  task automatic do_reset(input int off, input logic [9:0] idle);
    reset_n = 1'b0;
    off0 = off;
    slip_base = slip_total;
    drive(idle);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (4) begin
      drive(idle);
      tick();
    end
  endtask

  task automatic test_reset();
    raw_din = T11;
    #2 reset_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({bitslip, aligned, lock_lost, de, c1, c0, data_out}
        !== 14'h0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h required 0",
               {bitslip, aligned, lock_lost, de, c1, c0, data_out});
    end
    reset_n = 1'b1;
    off0 = 0;
    slip_base = slip_total;
    tick();
    checks++;
    if ({bitslip, aligned, lock_lost, de, c1, c0, data_out}
        !== 14'h0) begin
      errors++;
      $display("FAIL reset_first_edge: outputs=%h required 0",
               {bitslip, aligned, lock_lost, de, c1, c0, data_out});
    end
  endtask

  task automatic test_lock();
    bit early;
    early = 0;
    repeat (4) begin
      drive(IDLE);
      tick();
    end
    for (int k = 1; k <= LT; k++) begin
      drive(T00);
      tick();
      if (aligned !== 1'b0) early = 1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL lock_early: aligned=1 required 0");
    end
    drive(IDLE);
    tick();
    checks++;
    if (aligned !== 1'b1 || slip_total != slip_base) begin
      errors++;
      $display("FAIL lock_rise: aligned=%b slips=%0d required 1/0",
               aligned, slip_total - slip_base);
    end
    drive(IDLE);
    tick();
    checks++;
    if ({de, c1, c0, data_out} !== {3'b100, 8'hFF}) begin
      errors++;
      $display("FAIL lock_first_data: got %h required %h",
               {de, c1, c0, data_out}, {3'b100, 8'hFF});
    end
  endtask

  task automatic test_decode();
    logic [10:0] q[$];
    logic [10:0] e;
    logic [9:0]  w;
    logic [9:0]  toks[4];
    logic [7:0]  b;
    int kind;
    int idx;
    int since_tok;
    toks = '{T00, T01, T10, T11};
    disp = 0;
    since_tok = 0;
    for (int i = 0; i < 300; i++) begin
      kind = $urandom % 8;
      if (since_tok >= 100) kind = 0;
      if (kind == 0) begin
        idx = $urandom % 4;
        w = toks[idx];
        e = {1'b0, 2'(idx), 8'h00};
        since_tok = 0;
      end else if (kind < 4) begin
        w = 10'($urandom);
        while (is_tok(w)) w = 10'($urandom);
        e = {3'b100, spec_dec(w)};
        since_tok++;
      end else begin
        b = 8'($urandom);
        enc(b, w);
        e = {3'b100, b};
        since_tok++;
      end
      drive(w);
      q.push_back(e);
      tick();
      if (q.size() == 2) begin
        e = q.pop_front();
        checks++;
        if ({de, c1, c0, data_out} !== e || aligned !== 1'b1) begin
          errors++;
          $display("FAIL decode[%0d]: got %h al=%b required %h al=1",
                   i, {de, c1, c0, data_out}, aligned, e);
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    logic [13:0] got;
    logic [13:0] exp;
    logic [10:0] eo;
    drive(T00);
    tick();
    for (int k = 1; k <= 520; k++) begin
      drive(IDLE);
      tick();
      if (k == 1)        eo = 11'h0;
      else if (k <= 257) eo = {3'b100, 8'hFF};
      else               eo = 11'h0;
      exp = {(k == 513), (k <= 256), (k == 257), eo};
      got = {bitslip, aligned, lock_lost, de, c1, c0, data_out};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL lock_loss[%0d]: got %h required %h",
                 k, got, exp);
      end
    end
  endtask

  task automatic run_model(input logic [9:0] seq[$],
                           input string name);
    int run;
    bit locked;
    run = 0;
    locked = 0;
    for (int i = 0; i < seq.size(); i++) begin
      drive(seq[i]);
      tick();
      checks++;
      if ({bitslip, aligned} !== {1'b0, locked}) begin
        errors++;
        $display("FAIL %s[%0d]: bs/al=%b%b required 0%b",
                 name, i, bitslip, aligned, locked);
      end
      run = is_tok(seq[i]) ? run + 1 : 0;
      if (run >= LT) locked = 1;
    end
  endtask

  task automatic test_interrupt();
    logic [9:0] seq[$];
    do_reset(0, IDLE);
    repeat (63) seq.push_back(T00);
    seq.push_back(IDLE);
    repeat (67) seq.push_back(T00);
    run_model(seq, "interrupt");
  endtask

  task automatic test_reset_midrun();
    logic [9:0] seq[$];
    repeat (3) begin
      drive(IDLE);
      tick();
    end
    checks++;
    if ({aligned, de, data_out} !== {2'b11, 8'hFF}) begin
      errors++;
      $display("FAIL midrun_pre: got %h required %h",
               {aligned, de, data_out}, {2'b11, 8'hFF});
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bitslip, aligned, lock_lost, de, c1, c0, data_out}
        !== 14'h0) begin
      errors++;
      $display("FAIL midrun_async: outputs=%h required 0",
               {bitslip, aligned, lock_lost, de, c1, c0, data_out});
    end
    repeat (3) begin
      drive(IDLE);
      tick();
      checks++;
      if ({bitslip, aligned, lock_lost, de, c1, c0, data_out}
          !== 14'h0) begin
        errors++;
        $display("FAIL midrun_hold: outputs=%h required 0",
                 {bitslip, aligned, lock_lost, de, c1, c0, data_out});
      end
    end
    #2 reset_n = 1'b1;
    off0 = 0;
    slip_base = slip_total;
    drive(IDLE);
    tick();
    checks++;
    if ({bitslip, aligned, lock_lost, de, c1, c0, data_out}
        !== 14'h0) begin
      errors++;
      $display("FAIL midrun_release: outputs=%h required 0",
               {bitslip, aligned, lock_lost, de, c1, c0, data_out});
    end
    repeat (3) seq.push_back(IDLE);
    repeat (67) seq.push_back(T00);
    run_model(seq, "relock");
  endtask

  task automatic test_slip_search();
    int slips[$];
    int lock_n;
    lock_n = -1;
    do_reset(3, T00);
    for (int n = 1; n <= 3000; n++) begin
      drive(T00);
      tick();
      if (bitslip === 1'b1) slips.push_back(n);
      if (aligned === 1'b1) begin
        lock_n = n;
        break;
      end
    end
    checks++;
    if (lock_n < 0) begin
      errors++;
      $display("FAIL slip_timeout: no lock in 3000 cycles");
    end
    checks++;
    if (slips.size() != 10 - 3) begin
      errors++;
      $display("FAIL slip_count: got %0d required %0d",
               slips.size(), 10 - 3);
    end
    for (int i = 1; i < slips.size(); i++) begin
      checks++;
      if (slips[i] - slips[i-1] != SW + SWT + 1) begin
        errors++;
        $display("FAIL slip_gap[%0d]: got %0d required %0d",
                 i, slips[i] - slips[i-1], SW + SWT + 1);
      end
    end
    if (slips.size() > 0 && lock_n >= 0) begin
      checks++;
      if (lock_n - slips[slips.size()-1] != 1 + SWT + LT) begin
        errors++;
        $display("FAIL slip_lock_delay: got %0d required %0d",
                 lock_n - slips[slips.size()-1], 1 + SWT + LT);
      end
    end
    checks++;
    if (cur_off() != 0) begin
      errors++;
      $display("FAIL slip_offset: got %0d required 0", cur_off());
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_decode();
    test_lock_loss();
    test_interrupt();
    test_reset_midrun();
    test_slip_search();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
